// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared NOP word, RV32I opcode constants and instruction field positions.
package msrv32_pkg;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic [6:0] {
    OP_LOAD     = 7'h03,
    OP_MISC_MEM = 7'h0F,
    OP_IMM      = 7'h13,
    OP_AUIPC    = 7'h17,
    OP_STORE    = 7'h23,
    OP_REG      = 7'h33,
    OP_LUI      = 7'h37,
    OP_BRANCH   = 7'h63,
    OP_JALR     = 7'h67,
    OP_JAL      = 7'h6F,
    OP_SYSTEM   = 7'h73
  } rv32i_opcode_e;
  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_MSB    = 19;
  localparam int RS1_LSB    = 15;
  localparam int RS2_MSB    = 24;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;
  localparam int CSR_MSB    = 31;
  localparam int CSR_LSB    = 20;
  localparam int IMM_LSB    = 7;
  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    return op inside {OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/msrv32_opcode_check.sv
// msrv32_opcode_check: flags opcodes outside the RV32I base set; never flags a substituted NOP.
module msrv32_opcode_check
  import msrv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic       nop_i,
  output logic       illegal_o
);
  always_comb illegal_o = nop_i ? 1'b0 : ((opcode_i[1:0] != 2'b11) || !is_rv32i_opcode(opcode_i));
endmodule

// File: rtl/msrv32_instruction_mux.sv
// msrv32_instruction_mux: selects fetched word or NOP (flush / reset hold) and slices decode fields.
// Optional illegal-opcode flag when MSRV32_IMUX_ILLEGAL_DET_EN is defined.
module msrv32_instruction_mux
  import msrv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        flush_in,
  input  logic [31:0] ms_risc32_mp_instr_in,
`ifdef MSRV32_IMUX_ILLEGAL_DET_EN
  output logic        illegal_instr_out,
`endif
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out,
  output logic [4:0]  rs1addr_out,
  output logic [4:0]  rs2addr_out,
  output logic [4:0]  rdaddr_out,
  output logic [11:0] csr_addr_out,
  output logic [31:7] instr_out
);
  logic        rst_hold_q, rst_hold_d;
  logic        nop_sel;
  logic [31:0] sel_instr;
  always_comb rst_hold_d = ms_riscv32_mp_rst_in;
  always_ff @(posedge ms_riscv32_mp_clk_in) rst_hold_q <= rst_hold_d;
  always_comb begin
    nop_sel      = flush_in | rst_hold_q;
    sel_instr    = nop_sel ? NOP_INSTR : ms_risc32_mp_instr_in;
    opcode_out   = sel_instr[OPCODE_MSB:OPCODE_LSB];
    funct3_out   = sel_instr[FUNCT3_MSB:FUNCT3_LSB];
    funct7_out   = sel_instr[FUNCT7_MSB:FUNCT7_LSB];
    rs1addr_out  = sel_instr[RS1_MSB:RS1_LSB];
    rs2addr_out  = sel_instr[RS2_MSB:RS2_LSB];
    rdaddr_out   = sel_instr[RD_MSB:RD_LSB];
    csr_addr_out = sel_instr[CSR_MSB:CSR_LSB];
    instr_out    = sel_instr[31:IMM_LSB];
  end
`ifdef MSRV32_IMUX_ILLEGAL_DET_EN
  msrv32_opcode_check u_opcode_check (
    .opcode_i  (opcode_out),
    .nop_i     (nop_sel),
    .illegal_o (illegal_instr_out)
  );
`endif
endmodule

// File: tb/tb_msrv32_instruction_mux.sv
// tb_msrv32_instruction_mux: directed + random stimulus, scoreboard queue, negedge monitor.
module tb_msrv32_instruction_mux;
  typedef struct {
    logic [31:0] word;
    logic        illegal;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] instr = 32'h0020_81B3;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] csr;
  logic [31:7] imm;
  logic        illegal;
  logic        model_hold;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;
  always #5 clk = ~clk;
  msrv32_instruction_mux dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_in  (rst),
    .flush_in              (flush),
    .ms_risc32_mp_instr_in (instr),
`ifdef MSRV32_IMUX_ILLEGAL_DET_EN
    .illegal_instr_out     (illegal),
`endif
    .opcode_out            (opcode),
    .funct3_out            (funct3),
    .funct7_out            (funct7),
    .rs1addr_out           (rs1),
    .rs2addr_out           (rs2),
    .rdaddr_out            (rd),
    .csr_addr_out          (csr),
    .instr_out             (imm)
  );
`ifndef MSRV32_IMUX_ILLEGAL_DET_EN
  assign illegal = 1'b0;
`endif
  // Reference: a reset seen at the most recent edge forces NOP for the following cycle.
  always @(posedge clk) model_hold = rst;
  function automatic exp_t model(input logic r_hold, input logic fl, input logic [31:0] w);
    exp_t e;
    logic [6:0] op;
    logic nop;
    nop = r_hold || fl;
    e.word = nop ? 32'h0000_0013 : w;
    op = e.word[6:0];
    e.illegal = !nop && !(op == 7'h03 || op == 7'h0F || op == 7'h13 || op == 7'h17 ||
                          op == 7'h23 || op == 7'h33 || op == 7'h37 || op == 7'h63 ||
                          op == 7'h67 || op == 7'h6F || op == 7'h73);
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic fl, input logic [31:0] w);
    @(posedge clk);
    #2;
    rst = r;
    flush = fl;
    instr = w;
    sb.push_back(model(model_hold, fl, w));
  endtask
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [31:0] w;
      e = sb.pop_front();
      w = e.word;
      chk("opcode", 32'(opcode), 32'(w[6:0]));
      chk("rd",     32'(rd),     32'((w >> 7) & 32'h1F));
      chk("funct3", 32'(funct3), 32'((w >> 12) & 32'h7));
      chk("rs1",    32'(rs1),    32'((w >> 15) & 32'h1F));
      chk("rs2",    32'(rs2),    32'((w >> 20) & 32'h1F));
      chk("funct7", 32'(funct7), 32'(w >> 25));
      chk("csr",    32'(csr),    32'(w >> 20));
      chk("instr_out", 32'(imm), 32'(w >> 7));
`ifdef MSRV32_IMUX_ILLEGAL_DET_EN
      chk("illegal", 32'(illegal), 32'(e.illegal));
`endif
    end
  end
  initial begin
    int wait_cyc;
    step(1, 0, 32'h0020_81B3);
    step(1, 0, 32'h0020_81B3);
    step(0, 0, 32'h0020_81B3);
    step(0, 0, 32'h0020_81B3);
    step(0, 0, 32'h0000_1234);
    step(0, 1, 32'h0000_1234);
    step(0, 0, 32'h0000_1234);
    step(0, 0, 32'h3051_10F3);
    step(0, 1, 32'h3051_10F3);
    step(0, 0, 32'h0000_0000);
    step(0, 0, 32'h0000_0013);
    step(0, 1, 32'h0000_0000);
    step(1, 1, 32'hFFFF_FFFF);
    step(0, 0, 32'hFFFF_FFFF);
    step(0, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 0) ? {$urandom} & 32'hFFFF_FF80 | 32'($urandom_range(0, 7) * 16 + 3)
                                       : $urandom);
    wait_cyc = 0;
    while (sb.size() != 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
